// File: rtl/control_fsm_if.sv
// Control-unit handshake bundle: opcode/flash inputs in, datapath strobes and status out.
// The datapath side drives opcode and flash_en; the control unit drives everything else.
interface control_fsm_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic [6:0]       opcode;
  logic             flash_en;
  logic             ir_wren;
  logic             pc_inc;
  logic             regfile_wren;
  logic             halted;
  logic             illegal;
  logic [WIDTH-1:0] instret;
  logic [2:0]       state_dbg;

  modport master (
    output opcode, flash_en,
    input  ir_wren, pc_inc, regfile_wren, halted, illegal, instret, state_dbg
  );

  modport slave (
    input  opcode, flash_en,
    output ir_wren, pc_inc, regfile_wren, halted, illegal, instret, state_dbg
  );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle RV32I control unit: BOOT/FETCH/LATCH/DECODE/EXECUTE/WRITEBACK/HALT sequencer
// with registered Moore strobes, sticky halt/illegal flags and a retired-instruction counter.
module control_fsm #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  control_fsm_if.slave  bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    BOOT      = 3'd0,
    FETCH     = 3'd1,
    LATCH     = 3'd2,
    DECODE    = 3'd3,
    EXECUTE   = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_WB   = 3'd1,
    CLS_NOP  = 3'd2,
    CLS_SYS  = 3'd3,
    CLS_ILL  = 3'd4
  } cls_t;

  state_t           state;
  cls_t             cls;
  logic [CNT_W-1:0] wait_cnt;
  logic             ir_wren_q;
  logic             pc_inc_q;
  logic             regfile_wren_q;
  logic             halted_q;
  logic             illegal_q;
  logic [WIDTH-1:0] instret_q;

  function automatic cls_t classify(input logic [6:0] opc);
    cls_t c;
    case (opc)
      OPC_OP, OPC_OP_IMM: c = CLS_WB;
      OPC_MISC_MEM:       c = CLS_NOP;
      OPC_SYSTEM:         c = CLS_SYS;
      default:            c = CLS_ILL;
    endcase
    return c;
  endfunction

  // Strobes are set on the edge entering their state so they line up with state_dbg.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= BOOT;
      cls            <= CLS_NONE;
      wait_cnt       <= '0;
      ir_wren_q      <= 1'b0;
      pc_inc_q       <= 1'b0;
      regfile_wren_q <= 1'b0;
      halted_q       <= 1'b0;
      illegal_q      <= 1'b0;
      instret_q      <= '0;
    end else begin
      ir_wren_q      <= 1'b0;
      pc_inc_q       <= 1'b0;
      regfile_wren_q <= 1'b0;

      // WRITEBACK has already pulsed pc_inc, so the instruction counts as retired.
      if (state == WRITEBACK) begin
        instret_q <= instret_q + WIDTH'(1);
      end

      if (bus.flash_en && (state != BOOT)) begin
        state     <= BOOT;
        wait_cnt  <= '0;
        halted_q  <= 1'b0;
        illegal_q <= 1'b0;
      end else begin
        case (state)
          BOOT: begin
            if (!bus.flash_en) begin
              state    <= FETCH;
              wait_cnt <= LAT_M1;
            end
          end
          FETCH: begin
            if (wait_cnt != '0) begin
              wait_cnt <= wait_cnt - CNT_W'(1);
            end else begin
              state     <= LATCH;
              ir_wren_q <= 1'b1;
            end
          end
          LATCH: begin
            state <= DECODE;
          end
          DECODE: begin
            cls   <= classify(bus.opcode);
            state <= EXECUTE;
          end
          EXECUTE: begin
            case (cls)
              CLS_SYS: begin
                state    <= HALT;
                halted_q <= 1'b1;
              end
              CLS_ILL: begin
                state     <= HALT;
                illegal_q <= 1'b1;
              end
              default: begin
                state          <= WRITEBACK;
                pc_inc_q       <= 1'b1;
                regfile_wren_q <= (cls == CLS_WB);
              end
            endcase
          end
          WRITEBACK: begin
            state    <= FETCH;
            wait_cnt <= LAT_M1;
          end
          HALT: begin
            state <= HALT;
          end
          default: begin
            state <= BOOT;
          end
        endcase
      end
    end
  end

  assign bus.ir_wren      = ir_wren_q;
  assign bus.pc_inc       = pc_inc_q;
  assign bus.regfile_wren = regfile_wren_q;
  assign bus.halted       = halted_q;
  assign bus.illegal      = illegal_q;
  assign bus.instret      = instret_q;
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: scoreboard of expected retirements checked on every pc_inc,
// plus directed state/flag checks; a second narrow instance covers latency 3 and wrap.
module tb_control_fsm;

  localparam logic [6:0] OP   = 7'b0110011;
  localparam logic [6:0] FNC  = 7'b0001111;
  localparam logic [6:0] SYS  = 7'b1110011;
  localparam logic [6:0] BAD  = 7'b1111111;

  typedef struct {
    logic        rf;
    logic [31:0] cnt;
    int          gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst3 = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last1 = 0;
  int   last3 = 0;
  exp_t q1[$];
  exp_t q3[$];

  control_fsm_if #(.WIDTH(32)) if1 ();
  control_fsm_if #(.WIDTH(4))  if3 ();

  control_fsm #(.WIDTH(32), .MEM_LATENCY(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  control_fsm #(.WIDTH(4), .MEM_LATENCY(3)) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (if3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Retirement monitor, instance 1
  always @(negedge clk) begin
    if (!rst && if1.pc_inc) begin
      exp_t e;
      check("excl_ir_pc1", 64'(if1.ir_wren), 64'd0);
      check("retire_expected1", 64'(q1.size() > 0), 64'd1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("rf_wren1", 64'(if1.regfile_wren), 64'(e.rf));
        check("instret_at_wb1", 64'(if1.instret), 64'(e.cnt));
        if (e.gap != 0) check("gap1", 64'(cyc - last1), 64'(e.gap));
      end
      last1 = cyc;
    end
    if (!rst && if1.regfile_wren && !if1.pc_inc) check("rf_alone1", 64'(if1.pc_inc), 64'd1);
  end

  // Retirement monitor, instance 3
  always @(negedge clk) begin
    if (!rst3 && if3.pc_inc) begin
      exp_t e;
      check("excl_ir_pc3", 64'(if3.ir_wren), 64'd0);
      check("retire_expected3", 64'(q3.size() > 0), 64'd1);
      if (q3.size() > 0) begin
        e = q3.pop_front();
        check("rf_wren3", 64'(if3.regfile_wren), 64'(e.rf));
        check("instret_at_wb3", 64'(if3.instret), 64'(e.cnt));
        if (e.gap != 0) check("gap3", 64'(cyc - last3), 64'(e.gap));
      end
      last3 = cyc;
    end
  end

  task automatic push1(input int n, input logic rf, input int start, input int first_gap, input int gap);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.rf  = rf;
      e.cnt = 32'(start + i);
      e.gap = (i == 0) ? first_gap : gap;
      q1.push_back(e);
    end
  endtask

  task automatic wait_state1(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (if1.state_dbg !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(if1.state_dbg), 64'(s));
  endtask

  task automatic wait_instret1(input logic [31:0] v, input int budget, input string tag);
    int n = 0;
    while (if1.instret !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(if1.instret), 64'(v));
  endtask

  task automatic reset_outs1(input string tag);
    check(tag, {if1.state_dbg, if1.ir_wren, if1.pc_inc, if1.regfile_wren,
                if1.halted, if1.illegal, if1.instret}, 64'd0);
  endtask

  initial begin
    logic [2:0] seq_st [5];
    logic       seq_ir [5];
    logic [2:0] seq3   [8];
    int         bad;

    if1.opcode = OP;  if1.flash_en = 1'b0;
    if3.opcode = OP;  if3.flash_en = 1'b0;
    seq_st = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    seq_ir = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    seq3   = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1};

    repeat (3) @(negedge clk);
    reset_outs1("reset_outs");

    // OP stream from reset release: 10 retirements, one every 5 cycles
    rst = 1'b0;
    push1(10, 1'b1, 0, 0, 5);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("boot_seq_state", 64'(if1.state_dbg), 64'(seq_st[k]));
      check("boot_seq_irwren", 64'(if1.ir_wren), 64'(seq_ir[k]));
    end
    wait_instret1(32'd10, 60, "op_instret10");
    check("op_q_drained", 64'(q1.size()), 64'd0);

    // FENCE: pc_inc without regfile_wren
    if1.opcode = FNC;
    push1(4, 1'b0, 10, 5, 5);
    wait_instret1(32'd14, 40, "fence_instret14");
    check("fence_q_drained", 64'(q1.size()), 64'd0);

    // Three OPs then SYSTEM halts
    if1.opcode = OP;
    push1(3, 1'b1, 14, 5, 5);
    wait_instret1(32'd17, 30, "pre_sys_instret17");
    if1.opcode = SYS;
    wait_state1(3'd6, 15, "sys_halt_state");
    check("sys_flags", 64'({if1.halted, if1.illegal}), 64'd2);
    check("sys_instret", 64'(if1.instret), 64'd17);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (if1.state_dbg !== 3'd6 || if1.ir_wren || if1.pc_inc || if1.regfile_wren || !if1.halted)
        bad++;
    end
    check("halt_hold", 64'(bad), 64'd0);

    // Flash clears halt
    if1.flash_en = 1'b1;
    repeat (4) @(negedge clk);
    check("flash_clr_halt", 64'({if1.state_dbg, if1.halted, if1.illegal}), 64'd0);

    // Illegal opcode, then flash recovery
    if1.flash_en = 1'b0;
    if1.opcode = BAD;
    wait_state1(3'd6, 15, "ill_halt_state");
    check("ill_flags", 64'({if1.halted, if1.illegal}), 64'd1);
    check("ill_instret", 64'(if1.instret), 64'd17);
    if1.flash_en = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (if1.ir_wren || if1.pc_inc || if1.regfile_wren) bad++;
    end
    check("flash_no_strobe", 64'(bad), 64'd0);
    check("flash_clr_ill", 64'({if1.state_dbg, if1.halted, if1.illegal}), 64'd0);
    check("flash_instret_hold", 64'(if1.instret), 64'd17);
    if1.flash_en = 1'b0;
    if1.opcode = OP;
    push1(1, 1'b1, 17, 0, 0);
    @(negedge clk);
    check("resume_fetch", 64'(if1.state_dbg), 64'd1);
    wait_instret1(32'd18, 20, "resume_instret18");

    // Flash mid-instruction abandons it
    wait_state1(3'd3, 10, "reach_decode");
    if1.flash_en = 1'b1;
    @(negedge clk);
    check("mid_flash_state", 64'(if1.state_dbg), 64'd0);
    check("mid_flash_instret", 64'(if1.instret), 64'd18);
    if1.flash_en = 1'b0;

    // rst in EXECUTE wins over the pending writeback
    wait_state1(3'd4, 15, "reach_execute");
    rst = 1'b1;
    @(negedge clk);
    reset_outs1("mid_reset_outs");

    // Latency 3, 4-bit counter: 7 cycles per instruction and wrap 15 -> 0
    for (int i = 0; i < 17; i++) begin
      exp_t e;
      e.rf  = 1'b1;
      e.cnt = 32'(i % 16);
      e.gap = (i == 0) ? 0 : 7;
      q3.push_back(e);
    end
    rst3 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("lat3_seq", 64'(if3.state_dbg), 64'(seq3[k]));
    end
    begin
      int n = 0;
      while (q3.size() != 0 && n < 150) begin
        @(negedge clk);
        n++;
      end
    end
    check("lat3_q_drained", 64'(q3.size()), 64'd0);
    @(negedge clk);
    check("lat3_wrapped", 64'(if3.instret), 64'd1);
    rst3 = 1'b1;

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
Multi-cycle control unit that sequences the RV32I datapath. Consumes the opcode field of the latched instruction register and produces the datapath's ir_wren, pc_inc and regfile_wren strobes. Holds the core idle while flash programming is active and halts on SYSTEM or unsupported opcodes. Exposes a retired-instruction counter and debug state.

Parameters:
WIDTH, 32, width of the instret counter
MEM_LATENCY, 1, cycles from the PC being valid on the memory address until rd_data is valid (range 1..15)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
opcode  in  7  instruction[6:0] from the IR (rv32i_opcode_t)
flash_en  in  1  flash programming in progress; core must stay idle
ir_wren  out  1  load the IR from memory rd_data
pc_inc  out  1  advance the PC by 4
regfile_wren  out  1  write the ALU result to rd
halted  out  1  sticky; core stopped on SYSTEM
illegal  out  1  sticky; core stopped on an unsupported opcode
instret  out  WIDTH  retired-instruction count
state_dbg  out  3  current state encoding

Behaviour:
- One clock domain (clk). rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state = BOOT (encoding 0).
  - All strobes = 0; halted = 0; illegal = 0; instret = 0.
  - Wait counter = 0; latched class = NONE.
- Moore outputs: decoded only from registered state and registered class. There is no combinational path from opcode or flash_en to any output.
- State encodings: BOOT=0, FETCH=1, LATCH=2, DECODE=3, EXECUTE=4, WRITEBACK=5, HALT=6.
- BOOT: all strobes low. Stay while flash_en=1. Go to FETCH on the first cycle flash_en=0.
- FETCH: memory is addressed by the current PC.
  - On entry, the wait counter is loaded with MEM_LATENCY-1.
  - Stay while counter != 0, decrementing each cycle; go to LATCH when it reaches 0.
  - FETCH therefore lasts exactly MEM_LATENCY cycles.
- LATCH: ir_wren=1 for exactly one cycle. Go to DECODE.
- DECODE: opcode is now valid. Classify it and register the class:
  - 0110011 (OP) and 0010011 (OP_IMM) -> WB.
  - 0001111 (MISC_MEM/FENCE) -> NOP.
  - 1110011 (SYSTEM) -> SYS.
  - Any other value -> ILL.
  - Go to EXECUTE.
- EXECUTE: ALU settles; no strobes.
  - Class SYS -> HALT and set halted.
  - Class ILL -> HALT and set illegal.
  - Otherwise -> WRITEBACK.
- WRITEBACK: pc_inc=1, and regfile_wren=1 only if class=WB. instret increments by 1. Go to FETCH.
  - pc_inc must never coincide with ir_wren.
- HALT: all strobes low. halted and illegal hold.
  - The halting instruction is not retired; PC is not incremented, so PC points at the faulting instruction.
  - Leave only via rst or flash_en=1.
- Instruction timing: with MEM_LATENCY=L, each retired instruction takes L+4 cycles (5 cycles at L=1).
- flash_en=1 in any non-BOOT state, including mid-instruction or in HALT:
  - Next state is BOOT. No strobe is asserted in that cycle or later.
  - halted and illegal clear; the wait counter clears; instret holds its value.
  - A partially executed instruction is abandoned with no side effect.
- rst has priority over flash_en; rst mid-instruction returns to BOOT with all reset values.
- instret wraps modulo 2^WIDTH, from all-ones to 0, with no flag.
- Only one of ir_wren, pc_inc, regfile_wren is active per cycle, except pc_inc and regfile_wren together in WRITEBACK.

Test Plan:
- Reset with flash_en=0 -> state_dbg 0 -> 1 -> 2 -> 3 -> 4 -> 5; ir_wren pulses only in cycle 3 after reset release; all outputs 0 during rst.
- opcode=0110011 held, MEM_LATENCY=1, run 50 cycles -> 10 instructions retired; instret=10; regfile_wren and pc_inc high together once every 5 cycles.
- opcode=0001111 -> pc_inc pulses every 5 cycles, regfile_wren never asserts, instret increments.
- opcode=1110011 after 3 OP instructions -> halted=1, illegal=0, instret=3, state_dbg=6 held for 20 cycles, no further strobes.
- opcode=1111111 -> illegal=1, state_dbg=6; then flash_en=1 for 4 cycles -> state_dbg=0, illegal=0, instret unchanged; flash_en=0 -> fetch resumes.
- MEM_LATENCY=3, OP stream -> FETCH lasts 3 cycles, 7 cycles per instruction; instret preloaded to 2^WIDTH-1 wraps to 0 on the next WRITEBACK.
